// File: rtl/sipo_frame_rx_if.sv
// ----------------------------------------------------------------------------
// sipo_frame_rx_if
// Bundles the serial input, error-clear, parallel output handshake and
// status lines of the serial-in / parallel-out frame receiver.
//
// Signals
//   si_en    : bit strobe; si is only meaningful while si_en=1
//   si       : serial line, idle low, start bit high, data MSB first
//   clr_err  : synchronous clear of the sticky error flags
//   po       : received data word (WIDTH bits)
//   po_valid : po holds a word not yet taken by the consumer
//   po_ready : consumer accepts po when po_valid=1
//   busy     : receiver is inside a frame
//   par_err  : sticky parity error
//   ovf      : sticky overflow (a finished word was dropped)
//
// Modports
//   master : stimulus / consumer side
//   slave  : receiver side
// ----------------------------------------------------------------------------
interface sipo_frame_rx_if #(
  parameter int WIDTH = 4
);
  logic             si_en;
  logic             si;
  logic             clr_err;
  logic [WIDTH-1:0] po;
  logic             po_valid;
  logic             po_ready;
  logic             busy;
  logic             par_err;
  logic             ovf;

  modport master (
    output si_en, si, clr_err, po_ready,
    input  po, po_valid, busy, par_err, ovf
  );

  modport slave (
    input  si_en, si, clr_err, po_ready,
    output po, po_valid, busy, par_err, ovf
  );
endinterface

// File: rtl/sipo_frame_rx.sv
// ----------------------------------------------------------------------------
// sipo_frame_rx
// Serial-in / parallel-out frame receiver. A frame is a high start bit,
// WIDTH data bits (MSB first) and, when PARITY_EN=1, one even-parity bit.
// Bits are only sampled in cycles with si_en=1. A finished word is handed
// to a valid/ready output register; if that register is still occupied
// and not being taken in the same cycle, the new word is dropped and the
// sticky ovf flag is raised. A parity failure drops the word and raises
// the sticky par_err flag. Reception never waits for the consumer.
//
// Parameters
//   WIDTH     : data bits per frame and width of po (2..16)
//   PARITY_EN : 1 = frame carries an even-parity bit, 0 = no parity bit
//
// Ports
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : sipo_frame_rx_if slave modport (see interface for signal list)
// ----------------------------------------------------------------------------
module sipo_frame_rx #(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1
) (
  input logic            clk,
  input logic            rst,
  sipo_frame_rx_if.slave bus
);

  localparam int             CW         = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_CNT   = CW'(WIDTH - 1);
  localparam bit             HAS_PARITY = (PARITY_EN != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Returns 1 when data plus its parity bit do not have even parity.
  function automatic logic parity_bad(input logic [WIDTH-1:0] data,
                                      input logic             par_bit);
    return (^data) ^ par_bit;
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nxt_s;
  logic [WIDTH-1:0] sh_r;
  logic [WIDTH-1:0] sh_nxt_s;
  logic [WIDTH-1:0] shifted_s;
  logic [WIDTH-1:0] word_s;
  logic             deliver_s;
  logic             par_set_s;

  logic [WIDTH-1:0] po_r;
  logic [WIDTH-1:0] po_nxt_s;
  logic             po_valid_r;
  logic             po_valid_nxt_s;
  logic             ovf_set_s;
  logic             busy_r;
  logic             par_err_r;
  logic             par_err_nxt_s;
  logic             ovf_r;
  logic             ovf_nxt_s;

  assign shifted_s = {sh_r[WIDTH-2:0], bus.si};

  // Receive FSM: next state, shift/counter update and word completion.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    sh_nxt_s    = sh_r;
    word_s      = sh_r;
    deliver_s   = 1'b0;
    par_set_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.si_en && bus.si) begin
          state_nxt_s = DATA;
          cnt_nxt_s   = {CW{1'b0}};
          sh_nxt_s    = {WIDTH{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DATA: begin
        if (bus.si_en) begin
          sh_nxt_s  = shifted_s;
          cnt_nxt_s = cnt_r + CW'(1);
          if (cnt_r == LAST_CNT) begin
            if (HAS_PARITY) begin
              state_nxt_s = PARITY;
            end else begin
              // Without a parity bit the word is complete on this bit.
              state_nxt_s = IDLE;
              deliver_s   = 1'b1;
              word_s      = shifted_s;
            end
          end else begin
            state_nxt_s = DATA;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      PARITY: begin
        if (bus.si_en) begin
          state_nxt_s = IDLE;
          if (parity_bad(sh_r, bus.si)) begin
            par_set_s = 1'b1;
          end else begin
            deliver_s = 1'b1;
          end
        end else begin
          state_nxt_s = PARITY;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CW{1'b0}};
        sh_nxt_s    = {WIDTH{1'b0}};
      end
    endcase
  end

  // Output register: deliver into a free (or simultaneously drained) slot,
  // otherwise drop the word and flag overflow.
  always_comb begin
    po_nxt_s       = po_r;
    po_valid_nxt_s = po_valid_r;
    ovf_set_s      = 1'b0;
    if (deliver_s) begin
      if (!po_valid_r || bus.po_ready) begin
        po_nxt_s       = word_s;
        po_valid_nxt_s = 1'b1;
      end else begin
        ovf_set_s = 1'b1;
      end
    end else if (po_valid_r && bus.po_ready) begin
      po_valid_nxt_s = 1'b0;
    end else begin
      po_valid_nxt_s = po_valid_r;
    end
  end

  // Sticky flags: a new error in the clearing cycle keeps the flag set.
  always_comb begin
    par_err_nxt_s = par_set_s | (par_err_r & ~bus.clr_err);
    ovf_nxt_s     = ovf_set_s | (ovf_r & ~bus.clr_err);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      sh_r       <= {WIDTH{1'b0}};
      po_r       <= {WIDTH{1'b0}};
      po_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      par_err_r  <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      sh_r       <= sh_nxt_s;
      po_r       <= po_nxt_s;
      po_valid_r <= po_valid_nxt_s;
      busy_r     <= (state_nxt_s != IDLE);
      par_err_r  <= par_err_nxt_s;
      ovf_r      <= ovf_nxt_s;
    end
  end

  assign bus.po       = po_r;
  assign bus.po_valid = po_valid_r;
  assign bus.busy     = busy_r;
  assign bus.par_err  = par_err_r;
  assign bus.ovf      = ovf_r;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// ----------------------------------------------------------------------------
// tb_sipo_frame_rx
// Directed bench for sipo_frame_rx. Two receivers share clk/rst: one with
// the parity bit, one without; 'sel' routes the strobe to one of them and
// selects which outputs are observed. Inputs change on the falling edge,
// outputs are checked on the falling edge after the sampling edge.
// ----------------------------------------------------------------------------
module tb_sipo_frame_rx;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic si_en;
  logic si;
  logic clr_err;
  logic po_ready;

  always #5 clk = ~clk;

  sipo_frame_rx_if #(.WIDTH(4)) bus_p ();
  sipo_frame_rx_if #(.WIDTH(4)) bus_n ();

  assign bus_p.si_en    = si_en & ~sel;
  assign bus_p.si       = si;
  assign bus_p.clr_err  = clr_err;
  assign bus_p.po_ready = po_ready & ~sel;
  assign bus_n.si_en    = si_en & sel;
  assign bus_n.si       = si;
  assign bus_n.clr_err  = clr_err;
  assign bus_n.po_ready = po_ready & sel;

  sipo_frame_rx #(.WIDTH(4), .PARITY_EN(1)) dut_p (
    .clk (clk),
    .rst (rst),
    .bus (bus_p.slave)
  );

  sipo_frame_rx #(.WIDTH(4), .PARITY_EN(0)) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (bus_n.slave)
  );

  wire [3:0] po_o      = sel ? bus_n.po       : bus_p.po;
  wire       valid_o   = sel ? bus_n.po_valid : bus_p.po_valid;
  wire       busy_o    = sel ? bus_n.busy     : bus_p.busy;
  wire       par_err_o = sel ? bus_n.par_err  : bus_p.par_err;
  wire       ovf_o     = sel ? bus_n.ovf      : bus_p.ovf;

  int         total = 0;
  int         bad   = 0;
  logic [3:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    si    = b;
    si_en = 1'b1;
    tick();
  endtask

  task automatic gap();
    si    = 1'b0;
    si_en = 1'b0;
    tick();
  endtask

  // Start bit plus four data bits, MSB first.
  task automatic send_data(input logic [3:0] d);
    send_bit(1'b1);
    for (int i = 3; i >= 0; i--) send_bit(d[i]);
  endtask

  // One idle cycle with po_ready high to empty the output register.
  task automatic drain();
    po_ready = 1'b1;
    gap();
    po_ready = 1'b0;
  endtask

  // Compare a delivered word against the oldest expected word.
  task automatic check_po(input string tag);
    logic [3:0] exp;
    exp = 4'bxxxx;
    if (sb_q.size() > 0) exp = sb_q.pop_front();
    chk({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
    chk(tag, {28'd0, po_o}, {28'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    sel = 1'b0; si_en = 1'b0; si = 1'b0; clr_err = 1'b0; po_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_po",      {28'd0, po_o},      32'd0);
    chk("rst_valid",   {31'd0, valid_o},   32'd0);
    chk("rst_busy",    {31'd0, busy_o},    32'd0);
    chk("rst_par_err", {31'd0, par_err_o}, 32'd0);
    chk("rst_ovf",     {31'd0, ovf_o},     32'd0);

    // Good frame 1011 with parity 1, continuous strobe
    send_bit(1'b1);
    chk("t1_busy_start", {31'd0, busy_o}, 32'd1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    chk("t1_valid_early", {31'd0, valid_o}, 32'd0);
    sb_q.push_back(4'b1011);
    send_bit(1'b1);
    check_po("t1_po");
    chk("t1_par_err", {31'd0, par_err_o}, 32'd0);
    chk("t1_busy_end", {31'd0, busy_o}, 32'd0);
    drain();
    chk("t1_drained", {31'd0, valid_o}, 32'd0);

    // Bad parity drops the word; clr_err clears; set wins over clear
    send_data(4'b1011);
    send_bit(1'b0);
    chk("t2_valid", {31'd0, valid_o}, 32'd0);
    chk("t2_par_err", {31'd0, par_err_o}, 32'd1);
    clr_err = 1'b1;
    gap();
    clr_err = 1'b0;
    chk("t2_cleared", {31'd0, par_err_o}, 32'd0);
    send_data(4'b1011);
    clr_err = 1'b1;
    send_bit(1'b0);
    clr_err = 1'b0;
    chk("t2_set_wins", {31'd0, par_err_o}, 32'd1);
    clr_err = 1'b1;
    gap();
    clr_err = 1'b0;
    chk("t2_cleared2", {31'd0, par_err_o}, 32'd0);

    // Back-to-back frames with consumer stalled -> overflow
    send_data(4'b0110);
    sb_q.push_back(4'b0110);
    send_bit(1'b0);
    check_po("t3_first");
    send_data(4'b1001);
    send_bit(1'b0);
    chk("t3_po_held", {28'd0, po_o}, 32'h6);
    chk("t3_valid_held", {31'd0, valid_o}, 32'd1);
    chk("t3_ovf", {31'd0, ovf_o}, 32'd1);
    drain();
    chk("t3_drained", {31'd0, valid_o}, 32'd0);
    clr_err = 1'b1;
    gap();
    clr_err = 1'b0;
    chk("t3_ovf_clr", {31'd0, ovf_o}, 32'd0);

    // Strobe toggling 1,0,1,0 during frame 1100
    send_bit(1'b1);
    chk("t4_busy_start", {31'd0, busy_o}, 32'd1);
    gap();
    for (int i = 3; i >= 0; i--) begin
      send_bit(i >= 2 ? 1'b1 : 1'b0);
      gap();
      chk("t4_busy_data", {31'd0, busy_o}, 32'd1);
    end
    chk("t4_valid_early", {31'd0, valid_o}, 32'd0);
    sb_q.push_back(4'b1100);
    send_bit(1'b0);
    check_po("t4_po");
    chk("t4_busy_end", {31'd0, busy_o}, 32'd0);
    chk("t4_par_err", {31'd0, par_err_o}, 32'd0);
    drain();

    // Reset mid-frame, then a clean frame 0011
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    si_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("t5_rst_valid", {31'd0, valid_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_data(4'b0011);
    sb_q.push_back(4'b0011);
    send_bit(1'b0);
    check_po("t5_po");
    chk("t5_par_err", {31'd0, par_err_o}, 32'd0);
    chk("t5_ovf", {31'd0, ovf_o}, 32'd0);
    drain();

    // No-parity receiver: 1110, then immediate next frame 0101
    sel = 1'b1;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    chk("t6_valid_early", {31'd0, valid_o}, 32'd0);
    sb_q.push_back(4'b1110);
    send_bit(1'b0);
    check_po("t6_first");
    send_bit(1'b1);
    chk("t6_busy_restart", {31'd0, busy_o}, 32'd1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    sb_q.push_back(4'b0101);
    po_ready = 1'b1;
    send_bit(1'b1);
    po_ready = 1'b0;
    check_po("t6_second");
    chk("t6_ovf", {31'd0, ovf_o}, 32'd0);
    chk("t6_sb_empty", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
